// File: rtl/mont_final_sub.sv
`default_nettype none
// ============================================================================
// Module      : mont_final_sub
// Description : Final conditional subtraction of a Montgomery multiplier.
//               Computes R = (T >= M) ? T - M : T with a limb-serial
//               subtractor (one LIMB_W-bit limb per cycle, LSB limb first),
//               then selects D or T from the final borrow.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LIMB_W   : datapath limb width in bits (32, 64 or 128)
// Ports
//   clk      : in  rising-edge clock
//   resetn   : in  asynchronous active-low reset
//   start    : in  single-cycle request, accepted only when idle
//   in_t     : in  [514:0] upstream sum T (carry at bit 514)
//   in_m     : in  [513:0] modulus M
//   result   : out [513:0] reduced value R, held between done pulses
//   done     : out one-cycle completion pulse
//   busy     : out high while an operation is in flight
// Build option
//   MONT_FINAL_SUB_REG_OUT_EN : when defined, result and done pass through
//   one more register stage (latency NLIMBS+3 instead of NLIMBS+2).
// ============================================================================
module mont_final_sub #(
    parameter int LIMB_W = 64
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [514:0] in_t,
    input  logic [513:0] in_m,
    output logic [513:0] result,
    output logic         done,
    output logic         busy
);

    localparam int NLIMBS = (515 + LIMB_W - 1) / LIMB_W;
    localparam int PAD_W  = NLIMBS * LIMB_W;
    localparam int CNT_W  = $clog2(NLIMBS + 1);
    localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(NLIMBS - 1);

`ifdef MONT_FINAL_SUB_REG_OUT_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        SEL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PAD_W-1:0]   t_q, t_d;
    logic [PAD_W-1:0]   m_q, m_d;
    logic [PAD_W-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [513:0]       res_q, res_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [LIMB_W-1:0]  t_limb;
    logic [LIMB_W-1:0]  m_limb;
    logic [LIMB_W:0]    sub_limb;
    logic               accept;
    int                 limb_base;

    // A start arriving in the done cycle (or while the optional output
    // stage still holds a pending result) is dropped, not queued.
    assign accept = (state_q == IDLE) && start && !busy_q && !done;

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        m_d       = m_q;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;
        res_d     = res_q;

        limb_base = int'(cnt_q) * LIMB_W;
        t_limb    = t_q[limb_base +: LIMB_W];
        m_limb    = m_q[limb_base +: LIMB_W];
        // Extra MSB of the limb difference is the borrow out of this limb.
        sub_limb  = {1'b0, t_limb} - {1'b0, m_limb} - {{LIMB_W{1'b0}}, borrow_q};

        case (state_q)
            IDLE: begin
                if (accept) begin
                    t_d      = {{(PAD_W-515){1'b0}}, in_t};
                    m_d      = {{(PAD_W-514){1'b0}}, in_m};
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SUB;
                end
            end
            SUB: begin
                // Difference limbs enter from the top; after NLIMBS shifts
                // limb 0 sits at the bottom of diff_q.
                diff_d   = {sub_limb[LIMB_W-1:0], diff_q[PAD_W-1:LIMB_W]};
                borrow_d = sub_limb[LIMB_W];
                if (cnt_q == LAST_LIMB) begin
                    cnt_d   = '0;
                    state_d = SEL;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            SEL: begin
                // Final borrow set means T < M: keep T. Bits above 513 of
                // the difference are discarded here.
                res_d   = borrow_q ? t_q[513:0] : diff_q[513:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_q == DONE);
        // With the output stage, busy also covers the cycle in which the
        // result is still travelling through it.
        busy_d = (state_d != IDLE) || (REG_OUT && done_d);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            t_q      <= '0;
            m_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            m_q      <= m_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

`ifdef MONT_FINAL_SUB_REG_OUT_EN
    logic [513:0] res_out_q;
    logic         done_out_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_out_q  <= '0;
            done_out_q <= 1'b0;
        end else begin
            res_out_q  <= res_q;
            done_out_q <= done_q;
        end
    end

    assign result = res_out_q;
    assign done   = done_out_q;
`else
    assign result = res_q;
    assign done   = done_q;
`endif

    assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mont_final_sub.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mont_final_sub
// Description : Self-checking bench for mont_final_sub. A table of operand
//               records is applied in a loop; expected results go into a
//               scoreboard queue at stimulus time and are popped when done
//               pulses. Hand-written sequences cover start-while-busy,
//               start-during-done, result hold and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mont_final_sub;

    localparam int LIMB_W = 64;
    localparam int NLIMBS = (515 + LIMB_W - 1) / LIMB_W;
`ifdef MONT_FINAL_SUB_REG_OUT_EN
    localparam int LAT = NLIMBS + 3;
`else
    localparam int LAT = NLIMBS + 2;
`endif
    localparam int NVEC = 10;

    typedef struct {
        logic [514:0] t;
        logic [513:0] m;
        logic [513:0] exp;
        string        name;
    } vec_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [514:0] in_t;
    logic [513:0] in_m;
    logic [513:0] result;
    logic         done;
    logic         busy;

    int           checks = 0;
    int           errors = 0;
    logic [513:0] exp_q[$];
    vec_t         vecs[NVEC];

    mont_final_sub #(.LIMB_W(LIMB_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in_t   (in_t),
        .in_m   (in_m),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [513:0] act, input logic [513:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [513:0] ref_sub(input logic [514:0] t, input logic [513:0] m);
        logic [514:0] r;
        r = (t >= {1'b0, m}) ? (t - {1'b0, m}) : t;
        return r[513:0];
    endfunction

    function automatic logic [513:0] rand514();
        logic [543:0] r;
        for (int k = 0; k < 17; k++) r[k*32 +: 32] = $urandom;
        return r[513:0];
    endfunction

    // Drives one request and waits for its done pulse. With start_on_done,
    // start is held high during the done cycle and must be ignored.
    task automatic run_op(input logic [514:0] t, input logic [513:0] m,
                          input logic [513:0] exp, input string name,
                          input bit start_on_done);
        int   n;
        bit   seen;
        logic [513:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        in_t  = t;
        in_m  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_busy"}, {513'd0, busy}, 514'd1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < LAT + 20) begin
            @(posedge clk);
            n++;
            #1;
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, {513'd0, seen}, 514'd1);
        check({name, "_latency"}, 514'(n), 514'(LAT));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({name, "_result"}, result, e);
        end
        if (start_on_done) begin
            in_t  = 515'd77;
            in_m  = 514'd3;
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_done_width"}, {513'd0, done}, 514'd0);
        if (start_on_done)
            check({name, "_start_in_done_ignored"}, {513'd0, busy}, 514'd0);
    endtask

    initial begin
        logic [513:0] rm;
        logic [513:0] held;
        int           ndone;
        int           lat_seen;

        // ---------------- vector table ----------------
        vecs[0] = '{515'd5, 514'd3, 514'd2, "t5_m3"};
        vecs[1] = '{515'd2, 514'd3, 514'd2, "t2_m3"};
        vecs[2] = '{{3'b010, {8{64'h2A34_5C7E_9B1D_A16A}}},
                    {2'b10,  {8{64'h2A34_5C7E_9B1D_A16A}}}, 514'd0, "t_eq_m"};
        vecs[3] = '{515'd1 << 128, 514'd1, (514'd1 << 128) - 514'd1, "borrow_l0_l2"};
        vecs[4] = '{(515'd1 << 514) + 515'd1, 514'd1 << 513,
                    (514'd1 << 513) + 514'd1, "carry_bit"};
        // M all ones, T = 2^514 + 5: borrow crosses every limb boundary.
        vecs[5] = '{(515'd1 << 514) + 515'd5, {514{1'b1}}, 514'd6, "borrow_all_limbs"};
        vecs[6] = '{(515'd1 << 513), (514'd1 << 513) + 514'd1,
                    514'd1 << 513, "t_m_minus_1"};
        for (int i = 7; i < NVEC; i++) begin
            rm = rand514();
            rm[513] = 1'b1;
            vecs[i].m = rm;
            if (i == 8) vecs[i].t = {1'b0, rm} - 515'($urandom_range(1, 1000));
            else        vecs[i].t = {1'b0, rm} + {1'b0, rand514() >> 2};
            vecs[i].exp  = ref_sub(vecs[i].t, vecs[i].m);
            vecs[i].name = $sformatf("rand%0d", i);
        end

        // ---------------- reset ----------------
        resetn = 1'b0;
        start  = 1'b0;
        in_t   = '0;
        in_m   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 514'd0);
        check("reset_done", {513'd0, done}, 514'd0);
        check("reset_busy", {513'd0, busy}, 514'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        // ---------------- table loop ----------------
        for (int i = 0; i < NVEC; i++)
            run_op(vecs[i].t, vecs[i].m, vecs[i].exp, vecs[i].name, (i == 1));

        // ---------------- result holds between pulses ----------------
        held = result;
        in_t = 515'd12345;
        in_m = 514'd1;
        repeat (6) @(posedge clk);
        #1;
        check("result_hold", result, vecs[NVEC-1].exp);
        check("result_hold_stable", result, held);

        // ---------------- start while busy, operand change ----------------
        exp_q.push_back(514'd70);
        @(negedge clk);
        in_t  = 515'd100;
        in_m  = 514'd30;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        ndone    = 0;
        lat_seen = 0;
        for (int n = 1; n <= LAT + 15; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (n == 2 || n == 4) begin
                in_t  = 515'd7;
                in_m  = 514'd1;
                start = 1'b1;
            end
            if (n == 6) in_t = 515'd0;
            if (done) begin
                ndone++;
                if (lat_seen == 0) lat_seen = n;
                if (exp_q.size() > 0) check("busy_start_result", result, exp_q.pop_front());
            end
        end
        check("busy_start_single_done", 514'(ndone), 514'd1);
        check("busy_start_latency", 514'(lat_seen), 514'(LAT));

        // ---------------- reset in the middle of SUB ----------------
        @(negedge clk);
        in_t  = 515'd100;
        in_m  = 514'd30;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("midreset_result", result, 514'd0);
        check("midreset_busy", {513'd0, busy}, 514'd0);
        check("midreset_done", {513'd0, done}, 514'd0);
        @(negedge clk);
        resetn = 1'b1;
        ndone  = 0;
        for (int n = 0; n < LAT + 5; n++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midreset_no_done", 514'(ndone), 514'd0);
        run_op(515'd9, 514'd4, 514'd5, "after_reset", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mont_final_sub.md
MONT_FINAL_SUB -- requirements
Module: mont_final_sub

Interface
REQ-001 The block SHALL have parameter LIMB_W, default 64, meaning the datapath limb width in bits (legal values 32, 64, 128).
REQ-002 The block SHALL derive NLIMBS = ceil(515/LIMB_W) (9 at default) and zero-pad operands to NLIMBS*LIMB_W bits internally.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk, 1-bit input, rising-edge clock.
REQ-004 The block SHALL have resetn, 1-bit input, asynchronous active-low reset.
REQ-005 The block SHALL have start, 1-bit input, a single-cycle request that is sampled only in IDLE.
REQ-006 The block SHALL have in_t, 515-bit input, the upstream adder sum T (carry bit at [514]).
REQ-007 The block SHALL have in_m, 514-bit input, the modulus M.
REQ-008 The block SHALL have result, 514-bit output, the reduced value R.
REQ-009 The block SHALL have done, 1-bit output, a one-cycle completion pulse.
REQ-010 The block SHALL have busy, 1-bit output, high in every state except IDLE.

Function
REQ-011 The block SHALL compute R = T - M if T >= M, else R = T; R[513:0] is valid at done.
REQ-012 States SHALL be IDLE, SUB, SEL, DONE.
REQ-013 In IDLE, start=1 at an edge SHALL capture in_t and in_m into internal registers, clear the borrow, zero the limb counter, and move to SUB.
REQ-014 Operands SHALL be sampled only at the start edge; later changes on in_t/in_m SHALL NOT affect the result.
REQ-015 SUB SHALL process one LIMB_W-bit limb per cycle, LSB limb first: D_i = T_i - M_i - borrow, with borrow propagated to the next limb in a register.
REQ-016 SUB SHALL last exactly NLIMBS cycles, then move to SEL.
REQ-017 SEL SHALL load result with D[513:0] if the final borrow is 0, else with T[513:0], then move to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-019 Latency SHALL be NLIMBS+2 edges from the start edge to the first cycle with done=1 (11 at default).
REQ-020 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-021 start asserted in the cycle in which done=1 SHALL be ignored; a new start is accepted from the following IDLE cycle.
REQ-022 result SHALL hold its value between done pulses and update only in SEL.
REQ-023 T = M SHALL yield R = 0.
REQ-024 T < M SHALL yield R = T unchanged.
REQ-025 Borrow chains crossing every limb boundary SHALL be handled correctly.
REQ-026 No bit of the 515-bit difference above bit 513 SHALL reach result; in range, T < 2M is guaranteed by the upstream stage.

Reset
REQ-027 resetn=0 SHALL asynchronously force state to IDLE and set result=0, done=0, busy=0, borrow=0, and counter=0.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL be processed normally.

Configuration
REQ-029 The macro MONT_FINAL_SUB_REG_OUT_EN SHALL control an output register stage.
REQ-030 With MONT_FINAL_SUB_REG_OUT_EN defined, result and done SHALL pass through one additional register stage: latency becomes NLIMBS+3, busy stays high until done is asserted, and the stage resets to 0.
REQ-031 With MONT_FINAL_SUB_REG_OUT_EN undefined, there SHALL be no extra stage and latency SHALL be NLIMBS+2.

Verification
REQ-032 T=5, M=3, start one cycle -> result=2, done high for exactly 1 cycle, 11 edges after start (default parameters, no macro).
REQ-033 T=2, M=3 -> result=2; T=M=0x2A34...A16A -> result=0.
REQ-034 T=2^128, M=1 -> result=2^128-1 (borrow across limbs 0-2); T=2^514+1, M=2^513 -> result=2^513+1.
REQ-035 Pulse start twice more while busy, then change in_t mid-operation -> a single done, result from the originally captured operands.
REQ-036 Assert resetn=0 at SUB cycle 4 -> result=0, busy=0, no done; a subsequent T=9, M=4 run -> result=5.
REQ-037 Rerun REQ-032 with MONT_FINAL_SUB_REG_OUT_EN defined -> done 12 edges after start, result=2.
